// File: rtl/upower_pkg.sv
// Shared uPower front-end definitions: fetch FSM encoding and datapath widths.
package upower_pkg;
  localparam int INSTR_W    = 32;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/instruction_fetch_controller_if.sv
// Control, instruction-memory and decode-side signals of the fetch controller.
interface instruction_fetch_controller_if
  import upower_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic               start;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               imem_rd_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               inst_valid;
  logic               inst_ready;
  logic [INSTR_W-1:0] inst_data;
  logic [ADDR_W-1:0]  inst_pc;
  logic               busy;
  logic               done;

  modport master (
    input  start, redirect_valid, redirect_pc, imem_data, inst_ready,
    output imem_rd_en, imem_addr, inst_valid, inst_data, inst_pc, busy, done
  );

  modport slave (
    output start, redirect_valid, redirect_pc, imem_data, inst_ready,
    input  imem_rd_en, imem_addr, inst_valid, inst_data, inst_pc, busy, done
  );
endinterface

// File: rtl/fetch_buffer.sv
// DEPTH-entry FIFO of {pc, instruction}; flush wins over push.
module fetch_buffer #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_data,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_data,
  output logic [CW-1:0]     count
);
  logic [DEPTH-1:0][ADDR_W-1:0] pc_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PW-1:0]                rd_ptr, wr_ptr;

  assign head_pc   = pc_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= '0;
      data_q <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]   <= push_pc;
        data_q[wr_ptr] <= push_data;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/instruction_fetch_controller.sv
// Program-counter sequencer for the uPower instruction ROM with a small
// decoupling buffer towards decode and branch-redirect flush.
module instruction_fetch_controller
  import upower_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_INSTR = 6,
  parameter int RESET_PC  = 0,
  parameter int DEPTH     = 2
) (
  input logic                           clk,
  input logic                           reset_n,
  instruction_fetch_controller_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] NUM_A   = ADDR_W'(NUM_INSTR);
  localparam logic [ADDR_W-1:0] RESET_A = ADDR_W'(RESET_PC);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc, out_pc, pc_nxt;
  logic              outstanding;
  logic [CW-1:0]     count;
  logic              redir, pop, push, issue;

  assign redir = bus.redirect_valid && (state == FETCH || state == DRAIN);
  assign pop   = bus.inst_valid && bus.inst_ready;
  // A response landing in a redirect cycle belongs to the squashed path.
  assign push  = outstanding && !redir;
  // Reserve a slot for the in-flight word; a same-cycle pop frees one.
  assign issue = (state == FETCH) && !redir && (pc < NUM_A) &&
                 ((int'(count) + int'(outstanding) - int'(pop)) < DEPTH);
  assign pc_nxt = issue ? pc + ADDR_W'(1) : pc;

  assign bus.imem_rd_en = issue;
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = (count != '0);
  assign bus.busy       = (state == FETCH) || (state == DRAIN);
  assign bus.done       = (state == DONE);

  fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(INSTR_W)) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (redir),
    .push_pc   (out_pc),
    .push_data (bus.imem_data),
    .head_pc   (bus.inst_pc),
    .head_data (bus.inst_data),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_A;
      out_pc      <= '0;
      outstanding <= 1'b0;
    end else begin
      outstanding <= issue;
      if (issue) out_pc <= pc;
      pc <= pc_nxt;
      case (state)
        IDLE, DONE: if (bus.start) begin
          state <= FETCH;
          pc    <= RESET_A;
        end
        FETCH: if (redir) begin
          pc    <= bus.redirect_pc;
          state <= (bus.redirect_pc < NUM_A) ? FETCH : DRAIN;
        end else if (pc_nxt >= NUM_A) begin
          state <= DRAIN;
        end
        DRAIN: if (redir) begin
          pc    <= bus.redirect_pc;
          state <= (bus.redirect_pc < NUM_A) ? FETCH : DRAIN;
        end else if (count == '0 && !outstanding) begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
